// File: rtl/host_cmd_pkg.sv
// Shared encodings for the host command framer: command types, frame headers and FSM states.
package host_cmd_pkg;

    typedef enum logic [1:0] {
        CmdWr     = 2'd0,
        CmdRd     = 2'd1,
        CmdAluOp  = 2'd2,
        CmdAluNop = 2'd3
    } cmd_type_e;

    localparam logic [7:0] HdrWr     = 8'hAA;
    localparam logic [7:0] HdrRd     = 8'hBB;
    localparam logic [7:0] HdrAluOp  = 8'hCC;
    localparam logic [7:0] HdrAluNop = 8'hDD;

    typedef enum logic [2:0] {
        StIdle,
        StSendHdr,
        StSendAddr,
        StSendData,
        StSendOpa,
        StSendOpb,
        StSendFun,
        StWaitRsp
    } state_e;

    function automatic logic [7:0] header_byte(input cmd_type_e cmd);
        header_byte = HdrWr;
        unique case (cmd)
            CmdWr:     header_byte = HdrWr;
            CmdRd:     header_byte = HdrRd;
            CmdAluOp:  header_byte = HdrAluOp;
            CmdAluNop: header_byte = HdrAluNop;
        endcase
    endfunction

endpackage

// File: rtl/rsp_timer.sv
// Response wait timer: counts enabled cycles from 0 and flags the last allowed cycle.
module rsp_timer #(
    parameter int unsigned Cycles = 4096
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;

    logic [CntW-1:0] count;

    assign expired = enable && (count == CntW'(Cycles - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CntW'(1);
        end
    end

endmodule

// File: rtl/host_cmd_framer.sv
// Serialises host commands into UART byte frames and captures the single response byte.
// Define HOST_TIMEOUT_EN to bound the response wait with an rsp_timer instance.
module host_cmd_framer
    import host_cmd_pkg::*;
#(
    parameter int unsigned Data_width     = 8,
    parameter int unsigned Address_width  = 4,
    parameter int unsigned Timeout_cycles = 4096
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_type,
    input  logic [Address_width-1:0] cmd_addr,
    input  logic [Data_width-1:0]    cmd_wdata,
    input  logic [Data_width-1:0]    cmd_op_a,
    input  logic [Data_width-1:0]    cmd_op_b,
    input  logic [3:0]               cmd_fun,
    output logic [Data_width-1:0]    TX_p_data,
    output logic                     TX_d_valid,
    input  logic                     TX_busy,
    input  logic [Data_width-1:0]    RX_p_data,
    input  logic                     RX_d_valid,
    output logic [Data_width-1:0]    rsp_data,
    output logic                     rsp_valid,
    output logic                     rsp_timeout
);

    if (Data_width < 8 || Address_width > Data_width || Timeout_cycles < 2) begin : g_bad_params
        $error("host_cmd_framer: unsupported parameter combination");
    end

    state_e                   state;
    state_e                   next_state;
    cmd_type_e                type_q;
    logic [Address_width-1:0] addr_q;
    logic [Data_width-1:0]    wdata_q;
    logic [Data_width-1:0]    op_a_q;
    logic [Data_width-1:0]    op_b_q;
    logic [3:0]               fun_q;
    logic [Data_width-1:0]    next_byte;
    logic                     tx_accept;

    assign cmd_ready = (state == StIdle);
    assign tx_accept = TX_d_valid && !TX_busy;

    // Byte that follows the one currently on TX_p_data; StWaitRsp marks end of frame.
    always_comb begin
        next_state = StWaitRsp;
        next_byte  = '0;
        case (state)
            StSendHdr: begin
                case (type_q)
                    CmdWr, CmdRd: begin
                        next_state = StSendAddr;
                        next_byte  = Data_width'(addr_q);
                    end
                    CmdAluOp: begin
                        next_state = StSendOpa;
                        next_byte  = op_a_q;
                    end
                    default: begin
                        next_state = StSendFun;
                        next_byte  = Data_width'(fun_q);
                    end
                endcase
            end
            StSendAddr: begin
                if (type_q == CmdWr) begin
                    next_state = StSendData;
                    next_byte  = wdata_q;
                end
            end
            StSendOpa: begin
                next_state = StSendOpb;
                next_byte  = op_b_q;
            end
            StSendOpb: begin
                next_state = StSendFun;
                next_byte  = Data_width'(fun_q);
            end
            default: ;
        endcase
    end

`ifdef HOST_TIMEOUT_EN
    logic expired;

    rsp_timer #(
        .Cycles(Timeout_cycles)
    ) u_rsp_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (state != StWaitRsp),
        .enable (state == StWaitRsp),
        .expired(expired)
    );
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= StIdle;
            type_q     <= CmdWr;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            fun_q      <= '0;
            TX_p_data  <= '0;
            TX_d_valid <= 1'b0;
            rsp_data   <= '0;
            rsp_valid  <= 1'b0;
`ifdef HOST_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef HOST_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        type_q     <= cmd_type_e'(cmd_type);
                        addr_q     <= cmd_addr;
                        wdata_q    <= cmd_wdata;
                        op_a_q     <= cmd_op_a;
                        op_b_q     <= cmd_op_b;
                        fun_q      <= cmd_fun;
                        TX_p_data  <= Data_width'(header_byte(cmd_type_e'(cmd_type)));
                        TX_d_valid <= 1'b1;
                        state      <= StSendHdr;
                    end
                end
                StWaitRsp: begin
                    // A response landing in the expiry cycle takes priority over the timeout.
                    if (RX_d_valid) begin
                        rsp_data  <= RX_p_data;
                        rsp_valid <= 1'b1;
                        state     <= StIdle;
                    end
`ifdef HOST_TIMEOUT_EN
                    else if (expired) begin
                        rsp_timeout <= 1'b1;
                        state       <= StIdle;
                    end
`endif
                end
                default: begin
                    if (tx_accept) begin
                        state      <= next_state;
                        TX_p_data  <= next_byte;
                        TX_d_valid <= (next_state != StWaitRsp);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_cmd_framer.sv
// Bench for host_cmd_framer: table of command frames checked through TX/RSP scoreboards.
module tb_host_cmd_framer;

    typedef struct {
        logic [1:0] typ;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] op_a;
        logic [7:0] op_b;
        logic [3:0] fun;
        int         busy;
        bit         spam;
        logic [7:0] rx;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
    } vec_t;

    logic       CLK;
    logic       RST;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [7:0] cmd_op_a;
    logic [7:0] cmd_op_b;
    logic [3:0] cmd_fun;
    logic [7:0] TX_p_data;
    logic       TX_d_valid;
    logic       TX_busy;
    logic [7:0] RX_p_data;
    logic       RX_d_valid;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_timeout;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rsp_q[$];
    vec_t       vecs[6];

    host_cmd_framer #(
        .Data_width    (8),
        .Address_width (4),
        .Timeout_cycles(16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_op_a   (cmd_op_a),
        .cmd_op_b   (cmd_op_b),
        .cmd_fun    (cmd_fun),
        .TX_p_data  (TX_p_data),
        .TX_d_valid (TX_d_valid),
        .TX_busy    (TX_busy),
        .RX_p_data  (RX_p_data),
        .RX_d_valid (RX_d_valid),
        .rsp_data   (rsp_data),
        .rsp_valid  (rsp_valid),
        .rsp_timeout(rsp_timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] typ, input logic [3:0] addr,
                                input logic [7:0] wdata, input logic [7:0] op_a,
                                input logic [7:0] op_b, input logic [3:0] fun, input int busy,
                                input bit spam, input logic [7:0] rx, input int nbytes,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3);
        vec_t v;
        v.typ = typ; v.addr = addr; v.wdata = wdata; v.op_a = op_a; v.op_b = op_b;
        v.fun = fun; v.busy = busy; v.spam = spam; v.rx = rx; v.nbytes = nbytes;
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
        return v;
    endfunction

    // Scoreboard consumer: every accepted TX byte and every rsp_valid pops an expectation.
    initial begin
        logic       prev_hold;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("tx_stable_valid", TX_d_valid, 1);
                    check("tx_stable_data", TX_p_data, prev_data);
                end
                if (TX_d_valid && !TX_busy) begin
                    if (tx_q.size() == 0) begin
                        check("tx_unexpected", TX_d_valid, 0);
                    end else begin
                        e = tx_q.pop_front();
                        check("tx_byte", TX_p_data, e);
                    end
                end
                if (rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        check("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        e = rsp_q.pop_front();
                        check("rsp_data", rsp_data, e);
                    end
                end
                prev_hold = TX_d_valid && TX_busy;
                prev_data = TX_p_data;
            end
        end
    end

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge CLK);
        while (cmd_ready !== 1'b1 && g < 200) begin
            @(negedge CLK);
            g++;
        end
        check("cmd_ready_idle", cmd_ready, 1);
    endtask

    // Issues one command and returns at the last frame cycle (after its byte is consumed).
    task automatic run_frame(input vec_t v, output int cyc);
        wait_idle();
        @(posedge CLK); #1;
        tx_q.push_back(v.b0);
        if (v.nbytes >= 2) tx_q.push_back(v.b1);
        if (v.nbytes >= 3) tx_q.push_back(v.b2);
        if (v.nbytes >= 4) tx_q.push_back(v.b3);
        cmd_type  = v.typ;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_op_a  = v.op_a;
        cmd_op_b  = v.op_b;
        cmd_fun   = v.fun;
        cmd_valid = 1'b1;
        TX_busy   = (v.busy >= 1);
        @(posedge CLK); #1;
        cyc = 1;
        if (v.spam) begin
            cmd_type  = ~v.typ;
            cmd_addr  = ~v.addr;
            cmd_wdata = 8'hEE;
            cmd_op_a  = 8'hEE;
            cmd_op_b  = 8'hEE;
            cmd_fun   = ~v.fun;
        end else begin
            cmd_valid = 1'b0;
        end
        forever begin
            @(negedge CLK); #1;
            if (cyc == 1) begin
                check("hdr_valid", TX_d_valid, 1);
                check("ready_low_in_frame", cmd_ready, 0);
            end
            if (tx_q.size() == 0) break;
            if (cyc >= 60) begin
                check("frame_timeout", tx_q.size(), 0);
                tx_q.delete();
                break;
            end
            @(posedge CLK); #1;
            cyc++;
            TX_busy = (cyc <= v.busy);
        end
        check("frame_cycles", cyc, v.nbytes + v.busy);
        cmd_valid = 1'b0;
        TX_busy   = 1'b0;
    endtask

    task automatic respond(input logic [7:0] rx);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("wait_tx_idle", TX_d_valid, 0);
        check("wait_not_ready", cmd_ready, 0);
        @(posedge CLK); #1;
        RX_p_data  = rx;
        RX_d_valid = 1'b1;
        rsp_q.push_back(rx);
        @(posedge CLK); #1;
        RX_d_valid = 1'b0;
        @(negedge CLK); #1;
        check("rsp_seen", rsp_q.size(), 0);
        check("idle_after_rsp", cmd_ready, 1);
    endtask

    task automatic run_vector(input vec_t v);
        int c;
        run_frame(v, c);
        respond(v.rx);
    endtask

    task automatic stray_rx(input logic [7:0] exp_rsp);
        @(posedge CLK); #1;
        RX_p_data  = 8'hEE;
        RX_d_valid = 1'b1;
        @(posedge CLK); #1;
        RX_d_valid = 1'b0;
        @(negedge CLK);
        check("stray_rx_rsp_data", rsp_data, exp_rsp);
        check("stray_rx_no_valid", rsp_valid, 0);
    endtask

    initial begin
        int   c;
        int   k;
        logic saw;
        RST = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_addr = '0; cmd_wdata = '0;
        cmd_op_a = '0; cmd_op_b = '0; cmd_fun = '0; TX_busy = 1'b0;
        RX_p_data = '0; RX_d_valid = 1'b0;

        @(negedge CLK);
        check("rst_tx_valid", TX_d_valid, 0);
        check("rst_tx_data", TX_p_data, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        @(posedge CLK); #3;
        RST = 1'b0;

        // typ addr wdata op_a op_b fun busy spam rx n bytes
        vecs[0] = mk(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 0, 8'h3C, 3,
                     8'hAA, 8'h05, 8'h3C, 8'h00);
        vecs[1] = mk(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 3, 0, 8'h77, 2,
                     8'hBB, 8'h02, 8'h00, 8'h00);
        vecs[2] = mk(2'd2, 4'h0, 8'h00, 8'h10, 8'h05, 4'h0, 0, 1, 8'h15, 4,
                     8'hCC, 8'h10, 8'h05, 8'h00);
        vecs[3] = mk(2'd0, 4'hF, 8'hA5, 8'h00, 8'h00, 4'h0, 1, 0, 8'h5A, 3,
                     8'hAA, 8'h0F, 8'hA5, 8'h00);
        vecs[4] = mk(2'd2, 4'h0, 8'h00, 8'hFF, 8'h80, 4'hF, 2, 0, 8'h00, 4,
                     8'hCC, 8'hFF, 8'h80, 8'h0F);
        vecs[5] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h1, 0, 0, 8'h42, 2,
                     8'hDD, 8'h01, 8'h00, 8'h00);

        for (int i = 0; i < 6; i++) begin
            run_vector(vecs[i]);
        end

        stray_rx(8'h42);

        // ALU_NOP with no response.
        run_frame(mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h1, 0, 0, 8'h00, 2,
                     8'hDD, 8'h01, 8'h00, 8'h00), c);
`ifdef HOST_TIMEOUT_EN
        for (k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (rsp_timeout) break;
        end
        check("timeout_cycle", k, 16);
        check("timeout_back_idle", cmd_ready, 1);
        @(negedge CLK);
        check("timeout_pulse_width", rsp_timeout, 0);

        // Response arriving in the expiry cycle must win over the timeout.
        run_frame(mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3, 0, 0, 8'h00, 2,
                     8'hDD, 8'h03, 8'h00, 8'h00), c);
        @(posedge CLK); #1;
        repeat (15) begin
            @(posedge CLK); #1;
        end
        RX_p_data  = 8'h3C;
        RX_d_valid = 1'b1;
        rsp_q.push_back(8'h3C);
        @(posedge CLK); #1;
        RX_d_valid = 1'b0;
        @(negedge CLK);
        check("race_no_timeout", rsp_timeout, 0);
        check("race_rsp_wins", rsp_valid, 1);
        #1;
        check("race_rsp_seen", rsp_q.size(), 0);
        saw = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (rsp_timeout) saw = 1'b1;
        end
        check("race_no_late_timeout", saw, 0);
`else
        saw = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (rsp_timeout) saw = 1'b1;
        end
        check("no_timeout", saw, 0);
        check("wait_forever", cmd_ready, 0);
        @(posedge CLK); #1;
        RX_p_data  = 8'h5A;
        RX_d_valid = 1'b1;
        rsp_q.push_back(8'h5A);
        @(posedge CLK); #1;
        RX_d_valid = 1'b0;
        @(negedge CLK); #1;
        check("late_rsp_seen", rsp_q.size(), 0);
`endif

        // Reset while op_b is on the wire.
        wait_idle();
        @(posedge CLK); #1;
        tx_q.push_back(8'hCC);
        tx_q.push_back(8'h21);
        cmd_type = 2'd2; cmd_op_a = 8'h21; cmd_op_b = 8'h43; cmd_fun = 4'h5;
        cmd_valid = 1'b1;
        TX_busy = 1'b0;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        TX_busy = 1'b1;
        @(negedge CLK);
        check("opb_presented", TX_p_data, 8'h43);
        check("opb_valid", TX_d_valid, 1);
        #2;
        RST = 1'b1;
        #1;
        check("rst_async_tx_valid", TX_d_valid, 0);
        check("rst_async_tx_data", TX_p_data, 0);
        check("rst_async_ready", cmd_ready, 1);
        check("rst_partial_consumed", tx_q.size(), 0);
        repeat (2) @(posedge CLK);
        #3;
        RST = 1'b0;
        TX_busy = 1'b0;
        @(negedge CLK);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_tx_valid", TX_d_valid, 0);
        stray_rx(8'h00);

        run_vector(mk(2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 8'h99, 2,
                      8'hBB, 8'h09, 8'h00, 8'h00));

        repeat (3) @(negedge CLK);
        check("tx_queue_drained", tx_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/host_cmd_framer.md
HOST_CMD_FRAMER -- requirements
Module: host_cmd_framer

Interface
REQ-001 SHALL have parameter Data_width, default 8, meaning the UART byte and payload width.
REQ-002 SHALL have parameter Address_width, default 4, meaning the register-file address width.
REQ-003 SHALL have parameter Timeout_cycles, default 4096, meaning the number of clock cycles allowed for a response.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1 bit: a command request is present.
REQ-007 SHALL have port cmd_ready, output, 1 bit: the framer is IDLE and can accept a command.
REQ-008 SHALL have port cmd_type, input, 2 bits: 0=WR, 1=RD, 2=ALU_OP, 3=ALU_NOP.
REQ-009 SHALL have port cmd_addr, input, Address_width bits: register-file address.
REQ-010 SHALL have port cmd_wdata, input, Data_width bits: write data.
REQ-011 SHALL have ports cmd_op_a and cmd_op_b, input, Data_width bits each: ALU operands.
REQ-012 SHALL have port cmd_fun, input, 4 bits: ALU function.
REQ-013 SHALL have port TX_p_data, output, Data_width bits: byte sent to the UART transmitter.
REQ-014 SHALL have port TX_d_valid, output, 1 bit: TX_p_data is valid.
REQ-015 SHALL have port TX_busy, input, 1 bit: the UART transmitter cannot accept a byte.
REQ-016 SHALL have port RX_p_data, input, Data_width bits: byte from the UART receiver.
REQ-017 SHALL have port RX_d_valid, input, 1 bit: a single-cycle RX byte strobe.
REQ-018 SHALL have port rsp_data, output, Data_width bits: the captured response byte.
REQ-019 SHALL have port rsp_valid, output, 1 bit: one-cycle pulse when rsp_data is updated.
REQ-020 SHALL have port rsp_timeout, output, 1 bit: one-cycle pulse when the response wait expires.

Function
REQ-021 SHALL accept a command on the rising CLK edge where cmd_valid && cmd_ready, latching all cmd_* fields.
REQ-022 SHALL send the frame for each command type as follows.
- WR: AA, addr, wdata.
- RD: BB, addr.
- ALU_OP: CC, op_a, op_b, {0,fun}.
- ALU_NOP: DD, {0,fun}.
- The address byte SHALL be zero-extended to Data_width.
REQ-023 SHALL use the state machine IDLE -> SEND_HDR -> {SEND_ADDR -> SEND_DATA | SEND_OPA -> SEND_OPB -> SEND_FUN | SEND_FUN} -> WAIT_RSP -> IDLE.
- The path is selected by the latched cmd_type.
REQ-024 SHALL assert TX_d_valid with the header byte in the cycle after acceptance.
REQ-025 SHALL treat a byte as accepted on the edge where TX_d_valid && !TX_busy.
- TX_p_data and TX_d_valid SHALL stay stable until that edge.
REQ-026 SHALL present the next frame byte in the cycle after acceptance, with no idle gap.
REQ-027 SHALL enter WAIT_RSP after the last byte is accepted, with TX_d_valid low.
REQ-028 SHALL expect exactly one response byte for every command type, including WR.
REQ-029 In WAIT_RSP, on RX_d_valid, SHALL load rsp_data, pulse rsp_valid for one cycle, and return to IDLE.
REQ-030 SHALL ignore RX_d_valid in every state other than WAIT_RSP; rsp_data SHALL NOT change.
REQ-031 SHALL hold cmd_ready low outside IDLE and ignore cmd_valid there.
REQ-032 SHALL register all outputs, except that cmd_ready SHALL be a decode of the state register.

Reset
REQ-033 On RST high, SHALL immediately force the state to IDLE, with no clock needed.
REQ-034 On reset, SHALL drive TX_d_valid=0, TX_p_data=0, rsp_data=0, rsp_valid=0, rsp_timeout=0, and cmd_ready=1 once IDLE.
REQ-035 On reset mid-frame, SHALL abandon the partial frame with no resume; the latched command fields SHALL be cleared to 0.

Configuration
REQ-036 With HOST_TIMEOUT_EN defined, WAIT_RSP SHALL count cycles from 0.
- When Timeout_cycles-1 is reached without RX_d_valid, the framer SHALL pulse rsp_timeout and return to IDLE.
- If RX_d_valid arrives in the expiry cycle, the response SHALL win and no timeout SHALL be flagged.
REQ-037 Without HOST_TIMEOUT_EN, WAIT_RSP SHALL wait indefinitely, rsp_timeout SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-038 Package host_cmd_pkg SHALL hold the cmd_type encoding, the header constants AA/BB/CC/DD, and the state encoding.
REQ-039 The response timer SHALL be a sub-module rsp_timer (clear, enable, expired), instantiated only under HOST_TIMEOUT_EN.

Verification
REQ-040 WR addr=5, wdata=0x3C, TX_busy=0 -> bytes AA,05,3C on 3 consecutive cycles; RX 0x3C -> rsp_valid pulse, rsp_data=0x3C.
REQ-041 RD addr=2, TX_busy high 3 cycles at the header -> BB held stable 3 cycles, then 02; RX 0x77 -> rsp_data=0x77.
REQ-042 ALU_OP A=0x10, B=0x05, fun=0 -> CC,10,05,00; RX 0x15 -> rsp_data=0x15; cmd_valid during the frame is ignored.
REQ-043 ALU_NOP fun=1, with HOST_TIMEOUT_EN, Timeout_cycles=16, no RX -> DD,01, then rsp_timeout pulse exactly 16 cycles into WAIT_RSP, then back to IDLE.
REQ-044 RST asserted during SEND_OPB -> TX_d_valid=0 asynchronously; after release, cmd_ready=1; a stray RX_d_valid in IDLE leaves rsp_data unchanged.
